mem_access: RTL and testbench
=============================

# mem_access

Pipeline MEM stage of the 5-stage core. It sits between EXE and WB and produces the MEM→WB bus that the write-back stage consumes. The block decodes the memory-control field of the registered EXE→MEM bus and runs a request/acknowledge transaction on the data-memory port. It lane-aligns store data, and extracts and extends load data. It signals stage completion to the pipeline controller and holds its result until the controller advances the stage.

## Interface
Parameters: none. Bus widths come from macros in `common.vh`.
- `clk_i` in 1: core clock.
- `rst_i` in 1: asynchronous reset, active-high.
- `exe2mem_bus_ri` in `` `EXE2MEMBusSize `` (107): registered bus, MSB→LSB {mem_load, mem_store, mem_size[1:0], mem_unsigned, store_data[31:0], exe_result[31:0], wb_wdest[4:0], wb_we, pc[31:0]}.
- `mem2wb_bus_o` out `` `MEM2WBBusSize `` (70): MSB→LSB {wb_wdest[4:0], wb_we, mem_result[31:0], pc[31:0]}.
- `ctl_mem_valid_i` in 1: the stage holds a valid instruction.
- `ctl_mem_next_i` in 1: the controller transfers MEM→WB this cycle.
- `ctl_mem_over_o` out 1: the stage result is ready.
- `ctl_mem_dest_o` out 5: wb_wdest gated by valid, for hazard detection.
- `ctl_mem_misalign_o` out 1: a misaligned access was detected.
- `dm_req_o` out 1: data-memory request.
- `dm_we_o` out 1: the request is a store.
- `dm_addr_o` out 32: exe_result with bits [1:0] forced to 0.
- `dm_wstrb_o` out 4: byte write strobes; 0 for loads.
- `dm_wdata_o` out 32: lane-replicated store data.
- `dm_ack_i` in 1: the memory completes the request in this cycle.
- `dm_rdata_i` in 32: the load word; valid only in the cycle where req & ack are both high.

## Operation
- mem_size encoding: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- memop = mem_load | mem_store.
- Misaligned means either of these:
  - half access with addr[0] = 1;
  - word access with addr[1:0] ≠ 0.
- Misaligned accesses issue no request. `ctl_mem_misalign_o` = valid & memop & misaligned.
- FSM state has three values:
  - IDLE (reset state);
  - WAIT (request outstanding);
  - DONE (result held).
- `dm_req_o` = valid & memop & ~misaligned & (IDLE | WAIT).
- IDLE transitions:
  - req & ack → DONE;
  - req & ~ack → WAIT.
- WAIT transitions:
  - ack → DONE;
  - otherwise stay in WAIT; req stays high and address/data stay stable.
- DONE transitions:
  - `ctl_mem_next_i` → IDLE;
  - otherwise hold. No re-issue while held.
- rdata_q (32 bits, reset 0) captures `dm_rdata_i` on req & ack & mem_load.
- Store strobes and data:
  - byte: wstrb = 1 << addr[1:0], wdata = {4{sd[7:0]}};
  - half: wstrb = addr[1] ? 1100 : 0011, wdata = {2{sd[15:0]}};
  - word: wstrb = 1111, wdata = sd.
- Load extraction from rdata_q:
  - byte lane selected by addr[1:0];
  - half lane selected by addr[1];
  - sign-extended unless mem_unsigned.
- mem_result = (mem_load & ~misaligned) ? extracted : exe_result.
- Output wb_we = bus wb_we & ~(memop & misaligned).
- `ctl_mem_over_o` = valid & (~memop | misaligned | state == DONE).
- `ctl_mem_dest_o` = wb_wdest & {5{valid}}.

## Timing
- Reset (asynchronous): state = IDLE, rdata_q = 0, `dm_req_o` = 0 immediately.
- `ctl_mem_over_o` = 0 while reset is asserted.
- Non-memory op: over is combinational, in the same cycle as valid. Latency is 0.
- Memory op: `dm_req_o` rises combinationally in the first valid cycle.
- Ack in cycle k after the first request cycle (k ≥ 0) → over asserts in cycle k+1. Minimum latency is 1.
- Over and mem_result hold stable in DONE until `ctl_mem_next_i`.
- If valid drops in DONE without `ctl_mem_next_i` (flush), the state returns to IDLE.
- If valid drops in WAIT, the request is abandoned and the state returns to IDLE. The memory must tolerate withdrawn requests.
- Reset during WAIT: the request drops immediately and the state returns to IDLE; no ack is latched.
- `ctl_mem_next_i` with state ≠ DONE and a non-memory op: no state change.

## Structure
- `common.vh` gains:
  - `` `EXE2MEMBusSize `` (107);
  - the existing `` `MEM2WBBusSize `` (70);
  - size codes `` `MemSzB/H/W ``;
  - state codes `` `MemIdle/Wait/Done ``.
- Sub-module `mem_align`, purely combinational, takes addr[1:0], size, unsigned, sd and rdata_q. It produces wstrb, wdata, the extracted load value and misaligned.
- The FSM and rdata_q are kept in `mem_access`.

## Test plan
- ALU op: exe_result = 0x1234_5678, we = 1, dest = 7, valid → same-cycle over, bus result 0x1234_5678, `dm_req_o` = 0.
- lw @0x100, ack after 2 wait cycles, rdata = 0xDEAD_BEEF:
  - req is high for 3 cycles, addr = 0x100;
  - over asserts the next cycle with result 0xDEAD_BEEF;
  - the result holds until next.
- lb @0x103, rdata = 0x80xx_xxxx, zero-wait ack → result 0xFFFF_FF80. lbu from the same address → 0x0000_0080.
- sh @0x102, sd = 0xAAAA_BEEF → wstrb = 1100, wdata = 0xBEEF_BEEF, `dm_we_o` = 1.
- lw @0x101 → no request, misalign = 1, over same cycle, output wb_we = 0.
- Reset asserted in WAIT → req is 0 immediately. After release with valid still high, a fresh request is issued.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types for the MEM pipeline stage: bus layouts, size codes and FSM states.
package mem_access_pkg;

  localparam int EXE2MEM_BUS_SIZE = 107;
  localparam int MEM2WB_BUS_SIZE  = 70;

  // Size code 2'b11 is reserved and handled as a word everywhere.
  localparam logic [1:0] MEM_SZ_B = 2'b00;
  localparam logic [1:0] MEM_SZ_H = 2'b01;
  localparam logic [1:0] MEM_SZ_W = 2'b10;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_WAIT = 2'b01,
    MEM_DONE = 2'b10
  } mem_state_e;

  typedef struct packed {
    logic        mem_load;
    logic        mem_store;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] store_data;
    logic [31:0] exe_result;
    logic [4:0]  wb_wdest;
    logic        wb_we;
    logic [31:0] pc;
  } exe2mem_bus_t;

  typedef struct packed {
    logic [4:0]  wb_wdest;
    logic        wb_we;
    logic [31:0] mem_result;
    logic [31:0] pc;
  } mem2wb_bus_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MEM_SZ_B: return 1'b0;
      MEM_SZ_H: return addr_lo[0];
      default:  return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge port; the MEM stage is the master.
interface mem_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wstrb, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wstrb, wdata, output ack, rdata);
endinterface

// File: rtl/mem_align.sv
// Combinational lane logic: store strobes/replication, load extraction and alignment check.
module mem_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] sd_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o,
  output logic        misaligned_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b       = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign lane_h       = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  assign misaligned_o = is_misaligned(size_i, addr_lo_i);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    wstrb_o = 4'b1111;
    wdata_o = sd_i;
    load_o  = rdata_i;
    case (size_i)
      MEM_SZ_B: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{sd_i[7:0]}};
        load_o  = {{24{~unsigned_i & lane_b[7]}}, lane_b};
      end
      MEM_SZ_H: begin
        wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{sd_i[15:0]}};
        load_o  = {{16{~unsigned_i & lane_h[15]}}, lane_h};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: drives the data-memory handshake and builds the MEM->WB bus.
module mem_access
  import mem_access_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [EXE2MEM_BUS_SIZE-1:0] exe2mem_bus_ri,
  output logic [MEM2WB_BUS_SIZE-1:0]  mem2wb_bus_o,
  input  logic                        ctl_mem_valid_i,
  input  logic                        ctl_mem_next_i,
  output logic                        ctl_mem_over_o,
  output logic [4:0]                  ctl_mem_dest_o,
  output logic                        ctl_mem_misalign_o,
  mem_access_if.master                dm
);

  exe2mem_bus_t ex;
  mem2wb_bus_t  wb;
  mem_state_e   state_q, state_d;
  logic [31:0]  rdata_q;
  logic         memop, misaligned, req_ok, hs;
  logic [3:0]   wstrb;
  logic [31:0]  wdata, load_val;

  assign ex    = exe2mem_bus_ri;
  assign memop = ex.mem_load | ex.mem_store;

  mem_align u_align (
    .addr_lo_i   (ex.exe_result[1:0]),
    .size_i      (ex.mem_size),
    .unsigned_i  (ex.mem_unsigned),
    .sd_i        (ex.store_data),
    .rdata_i     (rdata_q),
    .wstrb_o     (wstrb),
    .wdata_o     (wdata),
    .load_o      (load_val),
    .misaligned_o(misaligned)
  );

  // Reset gates the request directly so it drops in the same cycle, not at the next edge.
  assign req_ok = ctl_mem_valid_i & memop & ~misaligned & (state_q != MEM_DONE);
  assign hs     = dm.req & dm.ack;

  assign dm.req   = ~rst_i & req_ok;
  assign dm.we    = dm.req & ex.mem_store;
  assign dm.addr  = {ex.exe_result[31:2], 2'b00};
  assign dm.wstrb = ex.mem_store ? wstrb : 4'b0000;
  assign dm.wdata = wdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE: if (dm.req) state_d = dm.ack ? MEM_DONE : MEM_WAIT;
      MEM_WAIT: begin
        if (!dm.req)     state_d = MEM_IDLE;
        else if (dm.ack) state_d = MEM_DONE;
      end
      MEM_DONE: if (ctl_mem_next_i || !ctl_mem_valid_i) state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= MEM_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (hs && ex.mem_load) rdata_q <= dm.rdata;
    end
  end

  assign wb.wb_wdest   = ex.wb_wdest;
  assign wb.wb_we      = ex.wb_we & ~(memop & misaligned);
  assign wb.mem_result = (ex.mem_load & ~misaligned) ? load_val : ex.exe_result;
  assign wb.pc         = ex.pc;
  assign mem2wb_bus_o  = wb;

  assign ctl_mem_over_o     = ~rst_i & ctl_mem_valid_i & (~memop | misaligned | (state_q == MEM_DONE));
  assign ctl_mem_dest_o     = ex.wb_wdest & {5{ctl_mem_valid_i}};
  assign ctl_mem_misalign_o = ctl_mem_valid_i & memop & misaligned;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected MEM->WB words are queued at issue and compared at over.
module tb_mem_access;
  import mem_access_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  exe2mem_bus_t                ex_s;
  logic [MEM2WB_BUS_SIZE-1:0]  mem2wb_bus;
  mem2wb_bus_t                 wb_s;
  logic                        valid = 1'b0, next = 1'b0;
  logic                        over, misalign;
  logic [4:0]                  dest;
  int                          checks = 0, failures = 0;
  mem2wb_bus_t                 sb[$];
  mem2wb_bus_t                 exp_w;

  mem_access_if dm_if ();

  mem_access dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .exe2mem_bus_ri    (ex_s),
    .mem2wb_bus_o      (mem2wb_bus),
    .ctl_mem_valid_i   (valid),
    .ctl_mem_next_i    (next),
    .ctl_mem_over_o    (over),
    .ctl_mem_dest_o    (dest),
    .ctl_mem_misalign_o(misalign),
    .dm                (dm_if.master)
  );

  assign wb_s = mem2wb_bus;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] sd, input logic [31:0] res, input logic [4:0] wd,
                        input logic we, input logic [31:0] pc);
    ex_s = '{mem_load: ld, mem_store: st, mem_size: sz, mem_unsigned: uns, store_data: sd,
             exe_result: res, wb_wdest: wd, wb_we: we, pc: pc};
  endtask

  task automatic push_exp(input logic [4:0] wd, input logic we, input logic [31:0] res, input logic [31:0] pc);
    sb.push_back('{wb_wdest: wd, wb_we: we, mem_result: res, pc: pc});
  endtask

  // Advances until over is seen or the budget runs out; the caller judges the outcome.
  task automatic wait_over(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (over) begin
        seen = 1'b1;
        return;
      end
      tick();
      #1;
    end
  endtask

  task automatic test_reset();
    set_op(1'b1, 1'b0, MEM_SZ_W, 1'b0, 32'h0, 32'h0000_0100, 5'd3, 1'b1, 32'h0000_1000);
    valid = 1'b1; dm_if.ack = 1'b1; dm_if.rdata = 32'h5555_5555;
    #1;
    checks++; if (dm_if.req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", dm_if.req); end
    checks++; if (over !== 1'b0) begin failures++; $display("FAIL reset_over got=%b exp=0", over); end
    checks++; if (wb_s.mem_result !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", wb_s.mem_result); end
    checks++; if (dest !== 5'd3) begin failures++; $display("FAIL reset_dest_valid got=%0d exp=3", dest); end
    valid = 1'b0; dm_if.ack = 1'b0;
    #1;
    checks++; if (dest !== 5'd0) begin failures++; $display("FAIL dest_gated got=%0d exp=0", dest); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (dm_if.req !== 1'b0) begin failures++; $display("FAIL idle_req got=%b exp=0", dm_if.req); end
  endtask

  task automatic test_alu();
    set_op(1'b0, 1'b0, MEM_SZ_W, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 5'd7, 1'b1, 32'h0000_2000);
    valid = 1'b1;
    push_exp(5'd7, 1'b1, 32'h1234_5678, 32'h0000_2000);
    #1;
    checks++; if (over !== 1'b1) begin failures++; $display("FAIL alu_over got=%b exp=1", over); end
    checks++; if (dm_if.req !== 1'b0) begin failures++; $display("FAIL alu_req got=%b exp=0", dm_if.req); end
    checks++; if (dest !== 5'd7) begin failures++; $display("FAIL alu_dest got=%0d exp=7", dest); end
    exp_w = sb.pop_front();
    checks++; if (wb_s !== exp_w) begin failures++; $display("FAIL alu_bus got=%h exp=%h", wb_s, exp_w); end
    next = 1'b1;
    tick();
    next = 1'b0;
    #1;
    checks++; if (over !== 1'b1) begin failures++; $display("FAIL alu_next_over got=%b exp=1", over); end
    valid = 1'b0;
  endtask

  task automatic test_load_wait();
    int  nreq = 0;
    bit  early = 1'b0, seen;
    set_op(1'b1, 1'b0, MEM_SZ_W, 1'b0, 32'h0, 32'h0000_0100, 5'd9, 1'b1, 32'h0000_3000);
    valid = 1'b1; dm_if.ack = 1'b0;
    push_exp(5'd9, 1'b1, 32'hDEAD_BEEF, 32'h0000_3000);
    #1;
    checks++; if (dm_if.addr !== 32'h0000_0100) begin failures++; $display("FAIL lw_addr got=%h exp=00000100", dm_if.addr); end
    checks++; if (dm_if.wstrb !== 4'b0000 || dm_if.we !== 1'b0) begin failures++; $display("FAIL lw_strb got=%b/%b exp=0000/0", dm_if.wstrb, dm_if.we); end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin dm_if.ack = 1'b1; dm_if.rdata = 32'hDEAD_BEEF; end
      #1;
      if (dm_if.req) nreq++;
      if (over) early = 1'b1;
      tick();
    end
    dm_if.ack = 1'b0; dm_if.rdata = 32'h0123_4567;
    checks++; if (nreq !== 3) begin failures++; $display("FAIL lw_req_cycles got=%0d exp=3", nreq); end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL lw_early_over got=%b exp=0", early); end
    #1;
    wait_over(1, seen);
    checks++; if (!seen) begin failures++; $display("FAIL lw_over_timeout got=0 exp=1"); end
    exp_w = sb.pop_front();
    checks++; if (wb_s !== exp_w) begin failures++; $display("FAIL lw_bus got=%h exp=%h", wb_s, exp_w); end
    checks++; if (dm_if.req !== 1'b0) begin failures++; $display("FAIL lw_done_req got=%b exp=0", dm_if.req); end
    tick();
    #1;
    checks++; if (over !== 1'b1 || wb_s !== exp_w) begin failures++; $display("FAIL lw_hold got=%b/%h exp=1/%h", over, wb_s, exp_w); end
    next = 1'b1;
    tick();
    next = 1'b0; valid = 1'b0;
  endtask

  task automatic test_load_byte();
    bit seen;
    logic [31:0] res_exp [2] = '{32'hFFFF_FF80, 32'h0000_0080};
    for (int u = 0; u < 2; u++) begin
      set_op(1'b1, 1'b0, MEM_SZ_B, u[0], 32'h0, 32'h0000_0103, 5'd4, 1'b1, 32'h0000_4000 + u);
      valid = 1'b1; dm_if.ack = 1'b1; dm_if.rdata = 32'h8012_3456;
      push_exp(5'd4, 1'b1, res_exp[u], 32'h0000_4000 + u);
      #1;
      checks++; if (dm_if.req !== 1'b1) begin failures++; $display("FAIL lb_req[%0d] got=%b exp=1", u, dm_if.req); end
      tick();
      dm_if.ack = 1'b0; dm_if.rdata = 32'h0;
      #1;
      wait_over(4, seen);
      checks++; if (!seen) begin failures++; $display("FAIL lb_over_timeout[%0d] got=0 exp=1", u); end
      exp_w = sb.pop_front();
      checks++; if (wb_s !== exp_w) begin failures++; $display("FAIL lb_bus[%0d] got=%h exp=%h", u, wb_s, exp_w); end
      next = 1'b1;
      tick();
      next = 1'b0; valid = 1'b0;
    end
  endtask

  task automatic test_store();
    bit seen;
    logic [1:0]  sz  [3] = '{MEM_SZ_H, MEM_SZ_B, MEM_SZ_W};
    logic [31:0] adr [3] = '{32'h0000_0102, 32'h0000_0101, 32'h0000_0104};
    logic [31:0] sd  [3] = '{32'hAAAA_BEEF, 32'h1234_565A, 32'hCAFE_F00D};
    logic [3:0]  stb [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] wd  [3] = '{32'hBEEF_BEEF, 32'h5A5A_5A5A, 32'hCAFE_F00D};
    for (int i = 0; i < 3; i++) begin
      set_op(1'b0, 1'b1, sz[i], 1'b0, sd[i], adr[i], 5'd0, 1'b0, 32'h0000_5000 + i);
      valid = 1'b1; dm_if.ack = 1'b1;
      push_exp(5'd0, 1'b0, adr[i], 32'h0000_5000 + i);
      #1;
      checks++; if (dm_if.we !== 1'b1 || dm_if.req !== 1'b1) begin failures++; $display("FAIL st_we[%0d] got=%b/%b exp=1/1", i, dm_if.req, dm_if.we); end
      checks++; if (dm_if.wstrb !== stb[i]) begin failures++; $display("FAIL st_wstrb[%0d] got=%b exp=%b", i, dm_if.wstrb, stb[i]); end
      checks++; if (dm_if.wdata !== wd[i]) begin failures++; $display("FAIL st_wdata[%0d] got=%h exp=%h", i, dm_if.wdata, wd[i]); end
      checks++; if (dm_if.addr !== {adr[i][31:2], 2'b00}) begin failures++; $display("FAIL st_addr[%0d] got=%h exp=%h", i, dm_if.addr, {adr[i][31:2], 2'b00}); end
      tick();
      dm_if.ack = 1'b0;
      #1;
      wait_over(4, seen);
      checks++; if (!seen) begin failures++; $display("FAIL st_over_timeout[%0d] got=0 exp=1", i); end
      exp_w = sb.pop_front();
      checks++; if (wb_s !== exp_w) begin failures++; $display("FAIL st_bus[%0d] got=%h exp=%h", i, wb_s, exp_w); end
      next = 1'b1;
      tick();
      next = 1'b0; valid = 1'b0;
    end
  endtask

  task automatic test_misalign();
    logic [1:0]  sz  [2] = '{MEM_SZ_W, MEM_SZ_H};
    logic [31:0] adr [2] = '{32'h0000_0101, 32'h0000_0103};
    for (int i = 0; i < 2; i++) begin
      set_op(1'b1, 1'b0, sz[i], 1'b0, 32'h0, adr[i], 5'd12, 1'b1, 32'h0000_6000 + i);
      valid = 1'b1; dm_if.ack = 1'b0;
      push_exp(5'd12, 1'b0, adr[i], 32'h0000_6000 + i);
      #1;
      checks++; if (dm_if.req !== 1'b0) begin failures++; $display("FAIL mis_req[%0d] got=%b exp=0", i, dm_if.req); end
      checks++; if (misalign !== 1'b1 || over !== 1'b1) begin failures++; $display("FAIL mis_flags[%0d] got=%b/%b exp=1/1", i, misalign, over); end
      exp_w = sb.pop_front();
      checks++; if (wb_s !== exp_w) begin failures++; $display("FAIL mis_bus[%0d] got=%h exp=%h", i, wb_s, exp_w); end
      next = 1'b1;
      tick();
      next = 1'b0; valid = 1'b0;
    end
    #1;
    checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL mis_invalid got=%b exp=0", misalign); end
  endtask

  task automatic test_reset_in_wait();
    bit seen;
    set_op(1'b1, 1'b0, MEM_SZ_W, 1'b0, 32'h0, 32'h0000_0200, 5'd5, 1'b1, 32'h0000_7000);
    valid = 1'b1; dm_if.ack = 1'b0;
    tick();
    #1;
    checks++; if (dm_if.req !== 1'b1 || over !== 1'b0) begin failures++; $display("FAIL rw_wait got=%b/%b exp=1/0", dm_if.req, over); end
    rst = 1'b1; dm_if.ack = 1'b1; dm_if.rdata = 32'h1111_1111;
    #1;
    checks++; if (dm_if.req !== 1'b0) begin failures++; $display("FAIL rw_req_drop got=%b exp=0", dm_if.req); end
    tick();
    rst = 1'b0; dm_if.ack = 1'b0;
    #1;
    checks++; if (dm_if.req !== 1'b1 || over !== 1'b0) begin failures++; $display("FAIL rw_reissue got=%b/%b exp=1/0", dm_if.req, over); end
    push_exp(5'd5, 1'b1, 32'h0BAD_F00D, 32'h0000_7000);
    dm_if.ack = 1'b1; dm_if.rdata = 32'h0BAD_F00D;
    tick();
    dm_if.ack = 1'b0;
    #1;
    wait_over(4, seen);
    checks++; if (!seen) begin failures++; $display("FAIL rw_over_timeout got=0 exp=1"); end
    exp_w = sb.pop_front();
    checks++; if (wb_s !== exp_w) begin failures++; $display("FAIL rw_bus got=%h exp=%h", wb_s, exp_w); end
    next = 1'b1;
    tick();
    next = 1'b0; valid = 1'b0;
  endtask

  task automatic test_flush();
    set_op(1'b1, 1'b0, MEM_SZ_H, 1'b0, 32'h0, 32'h0000_0302, 5'd6, 1'b1, 32'h0000_8000);
    valid = 1'b1; dm_if.ack = 1'b1; dm_if.rdata = 32'h8001_7FFF;
    push_exp(5'd6, 1'b1, 32'hFFFF_8001, 32'h0000_8000);
    tick();
    dm_if.ack = 1'b0;
    #1;
    checks++; if (dm_if.req !== 1'b0) begin failures++; $display("FAIL fl_no_reissue got=%b exp=0", dm_if.req); end
    exp_w = sb.pop_front();
    checks++; if (over !== 1'b1 || wb_s !== exp_w) begin failures++; $display("FAIL fl_lh_bus got=%b/%h exp=1/%h", over, wb_s, exp_w); end
    valid = 1'b0;
    tick();
    valid = 1'b1;
    #1;
    checks++; if (dm_if.req !== 1'b1 || over !== 1'b0) begin failures++; $display("FAIL fl_idle got=%b/%b exp=1/0", dm_if.req, over); end
    valid = 1'b0;
    tick();
  endtask

  initial begin
    dm_if.ack = 1'b0;
    dm_if.rdata = '0;
    set_op(1'b0, 1'b0, MEM_SZ_W, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    test_reset();
    test_alu();
    test_load_wait();
    test_load_byte();
    test_store();
    test_misalign();
    test_reset_in_wait();
    test_flush();
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
